// File: rtl/adcbuf_capture_ctrl.sv
// adcbuf_capture_ctrl
//   Sequences ADC-stream capture into a ping-pong BRAM write buffer.
//   When software arms the block, it waits for a trigger. It then skips an
//   optional number of post-trigger beats and writes every (decim+1)-th
//   accepted beat into the current bank. On completion it raises a sticky
//   done and flips to the other bank, so software drains one bank while the
//   next capture fills the other.
//
// Ports
//   clk, areset          capture clock, async active-high reset
//   arm, abort, trig     control pulses (trig is level-sampled while armed)
//   delay, length, decim capture setup, latched on arm
//   s_tdata/s_tvalid/s_tready  ADC AXI4-stream slave (never stalled)
//   bram_addr/wdata/we   BRAM write port, addr = {bank, word}
//   bank, busy, done, wcount   status
module adcbuf_capture_ctrl #(
    parameter int DATA_WIDTH  = 256,
    parameter int ADDR_WIDTH  = 12,
    parameter int DELAY_WIDTH = 16,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic                   arm,
    input  logic                   abort,
    input  logic                   trig,
    input  logic [DELAY_WIDTH-1:0] delay,
    input  logic [ADDR_WIDTH:0]    length,
    input  logic [DECIM_WIDTH-1:0] decim,
    input  logic [DATA_WIDTH-1:0]  s_tdata,
    input  logic                   s_tvalid,
    output logic                   s_tready,
    output logic [ADDR_WIDTH:0]    bram_addr,
    output logic [DATA_WIDTH-1:0]  bram_wdata,
    output logic                   bram_we,
    output logic                   bank,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH:0]    wcount
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_DELAY, S_CAPTURE, S_DONE
    } state_t;

    // Capture setup, frozen at arm time so software may reprogram freely.
    typedef struct packed {
        logic [DELAY_WIDTH-1:0] delay;
        logic [ADDR_WIDTH:0]    length;
        logic [DECIM_WIDTH-1:0] decim;
    } cfg_t;

    localparam logic [ADDR_WIDTH:0]    FULL_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]    WC_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [DELAY_WIDTH-1:0] DLY_ONE  = DELAY_WIDTH'(1);
    localparam logic [DECIM_WIDTH-1:0] DEC_ONE  = DECIM_WIDTH'(1);

    state_t                 state, state_n;
    cfg_t                   cfg_q;
    logic [DELAY_WIDTH-1:0] dly_cnt;
    logic [DECIM_WIDTH-1:0] dec_cnt;
    logic [ADDR_WIDTH:0]    len_eff;

    logic arm_go;     // arm accepted (idle/done, no abort)
    logic trig_go;    // trigger accepted while armed
    logic dly_beat;   // beat consumed by the post-trigger delay
    logic cap_beat;   // beat accepted during capture
    logic wr_beat;    // accepted beat that is actually written
    logic last_beat;  // the written beat completes the capture

    // A zero length encodes a full bank.
    assign len_eff = (cfg_q.length == '0) ? FULL_LEN : cfg_q.length;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge areset) begin
        if (areset) state <= S_IDLE;
        else        state <= state_n;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_n = state;
        if (abort) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (arm) state_n = S_ARMED;
                S_ARMED:   if (trig) state_n = (cfg_q.delay != '0) ? S_DELAY : S_CAPTURE;
                S_DELAY:   if (s_tvalid && dly_cnt == DLY_ONE) state_n = S_CAPTURE;
                S_CAPTURE: if (wr_beat && last_beat) state_n = S_DONE;
                S_DONE:    if (arm) state_n = S_ARMED;
                default:   state_n = S_IDLE;
            endcase
        end
    end

    // ---------------- output / strobe decode ----------------
    always_comb begin
        busy      = (state == S_ARMED) || (state == S_DELAY) || (state == S_CAPTURE);
        arm_go    = arm && !abort && ((state == S_IDLE) || (state == S_DONE));
        trig_go   = trig && !abort && (state == S_ARMED);
        dly_beat  = s_tvalid && !abort && (state == S_DELAY);
        cap_beat  = s_tvalid && !abort && (state == S_CAPTURE);
        wr_beat   = cap_beat && (dec_cnt == '0);
        last_beat = (wcount + WC_ONE) == len_eff;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            s_tready   <= 1'b0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_wdata <= '0;
            bank       <= 1'b0;
            done       <= 1'b0;
            wcount     <= '0;
            cfg_q      <= '0;
            dly_cnt    <= '0;
            dec_cnt    <= '0;
        end else begin
            s_tready <= 1'b1;
            bram_we  <= wr_beat;

            if (arm_go) begin
                cfg_q  <= '{delay: delay, length: length, decim: decim};
                wcount <= '0;
                done   <= 1'b0;
            end

            // The trigger-cycle beat is deliberately not consumed here.
            if (trig_go) begin
                dly_cnt <= cfg_q.delay;
                dec_cnt <= '0;
            end

            if (dly_beat) dly_cnt <= dly_cnt - DLY_ONE;

            if (cap_beat) dec_cnt <= (dec_cnt == '0) ? cfg_q.decim : dec_cnt - DEC_ONE;

            // Address is taken from the pre-toggle bank so the final write
            // still lands in the bank being filled.
            if (wr_beat) begin
                bram_addr  <= {bank, wcount[ADDR_WIDTH-1:0]};
                bram_wdata <= s_tdata;
                wcount     <= wcount + WC_ONE;
                if (last_beat) begin
                    done <= 1'b1;
                    bank <= ~bank;
                end
            end
        end
    end

endmodule

// File: tb/tb_adcbuf_capture_ctrl.sv
module tb_adcbuf_capture_ctrl;

    localparam int DW  = 256;
    localparam int AW  = 12;
    localparam int DLW = 16;
    localparam int DCW = 8;

    logic           clk = 1'b0;
    logic           areset = 1'b0;
    logic           arm = 1'b0, abort = 1'b0, trig = 1'b0;
    logic [DLW-1:0] delay = '0;
    logic [AW:0]    length = '0;
    logic [DCW-1:0] decim = '0;
    logic [DW-1:0]  s_tdata = '0;
    logic           s_tvalid = 1'b0;
    logic           s_tready;
    logic [AW:0]    bram_addr;
    logic [DW-1:0]  bram_wdata;
    logic           bram_we;
    logic           bank, busy, done;
    logic [AW:0]    wcount;

    adcbuf_capture_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DELAY_WIDTH(DLW), .DECIM_WIDTH(DCW)
    ) dut (
        .clk(clk), .areset(areset), .arm(arm), .abort(abort), .trig(trig),
        .delay(delay), .length(length), .decim(decim),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .bram_addr(bram_addr), .bram_wdata(bram_wdata), .bram_we(bram_we),
        .bank(bank), .busy(busy), .done(done), .wcount(wcount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW:0]   addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: every BRAM write must match the oldest expectation.
    always @(negedge clk) begin
        if (bram_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected", bram_addr, bram_wdata);
            end else begin
                e = exp_q.pop_front();
                if (bram_addr !== e.addr || bram_wdata !== e.data) begin
                    n_err++;
                    $display("FAIL write: got addr %0h data %0h want addr %0h data %0h",
                             bram_addr, bram_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input int d);
        wr_t w;
        w.addr = (AW+1)'(a);
        w.data = DW'(d);
        exp_q.push_back(w);
    endtask

    task automatic beat(input int d);
        s_tvalid = 1'b1;
        s_tdata  = DW'(d);
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Trigger with a live beat that must never be written.
    task automatic pulse_trig();
        trig     = 1'b1;
        s_tvalid = 1'b1;
        s_tdata  = DW'(32'hFF);
        tick();
        trig     = 1'b0;
        s_tvalid = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        #1 areset = 1'b1;
        tick(); tick();
        chk("rst_tready", 64'(s_tready), 0);
        chk("rst_we",     64'(bram_we), 0);
        chk("rst_addr",   64'(bram_addr), 0);
        chk("rst_bank",   64'(bank), 0);
        chk("rst_busy",   64'(busy), 0);
        chk("rst_done",   64'(done), 0);
        chk("rst_wcount", 64'(wcount), 0);
        areset = 1'b0;
        tick();
        chk("tready_after_rst", 64'(s_tready), 1);

        // ---------------- basic capture ----------------
        delay = 0; decim = 0; length = 4;
        pulse_arm();
        chk("t1_busy_armed", 64'(busy), 1);
        pulse_trig();
        for (int i = 0; i < 4; i++) push(i, 32'hA0 + i);
        for (int i = 0; i < 6; i++) begin
            beat(32'hA0 + i);
            if (i == 2) chk("t1_not_done_early", 64'(done), 0);
            if (i == 3) begin
                chk("t1_done",      64'(done), 1);
                chk("t1_last_we",   64'(bram_we), 1);
                chk("t1_last_addr", 64'(bram_addr), 3);
                chk("t1_bank",      64'(bank), 1);
                chk("t1_wcount",    64'(wcount), 4);
                chk("t1_busy",      64'(busy), 0);
            end
        end
        chk("t1_done_sticky", 64'(done), 1);

        // ---------------- delay + decimation ----------------
        delay = 3; decim = 2; length = 3;
        pulse_arm();
        chk("t2_done_cleared", 64'(done), 0);
        chk("t2_wcount_clr",   64'(wcount), 0);
        pulse_trig();
        push(13'h1000, 4); push(13'h1001, 7); push(13'h1002, 10);
        for (int v = 1; v <= 20; v++) begin
            beat(v);
            if (v == 9)  chk("t2_not_done_early", 64'(done), 0);
            if (v == 10) begin
                chk("t2_done",      64'(done), 1);
                chk("t2_last_addr", 64'(bram_addr), 13'h1002);
                chk("t2_bank",      64'(bank), 0);
                chk("t2_wcount",    64'(wcount), 3);
            end
        end

        // ---------------- full length with valid gaps ----------------
        delay = 0; decim = 0; length = 0;
        pulse_arm();
        pulse_trig();
        for (int i = 0; i < 4096; i++) push(i, 32'h10000 + i);
        for (int i = 0; i < 4096; i++) begin
            beat(32'h10000 + i);
            if (i == 4094) chk("t3_not_done_early", 64'(done), 0);
            tick();
        end
        chk("t3_done",   64'(done), 1);
        chk("t3_wcount", 64'(wcount), 13'h1000);
        chk("t3_bank",   64'(bank), 1);

        // ---------------- abort then re-arm ----------------
        length = 8;
        pulse_arm();
        pulse_trig();
        for (int i = 0; i < 5; i++) push(13'h1000 + i, 32'h50 + i);
        for (int i = 0; i < 5; i++) beat(32'h50 + i);
        abort = 1'b1; s_tvalid = 1'b1; s_tdata = DW'(32'h99);
        tick();
        abort = 1'b0; s_tvalid = 1'b0;
        beat(32'h9A); beat(32'h9B);
        chk("t4_busy",   64'(busy), 0);
        chk("t4_done",   64'(done), 0);
        chk("t4_bank",   64'(bank), 1);
        chk("t4_wcount", 64'(wcount), 5);
        pulse_arm();
        chk("t4_rearm_wcount", 64'(wcount), 0);
        chk("t4_rearm_busy",   64'(busy), 1);
        pulse_trig();
        for (int i = 0; i < 8; i++) push(13'h1000 + i, 32'h60 + i);
        for (int i = 0; i < 8; i++) begin
            arm = (i == 3);        // arm during capture is ignored
            beat(32'h60 + i);
            arm = 1'b0;
        end
        chk("t4_done",   64'(done), 1);
        chk("t4_wcount", 64'(wcount), 8);
        chk("t4_bank",   64'(bank), 0);

        // ---------------- ignored controls + ping-pong ----------------
        length = 2;
        abort = 1'b1; tick(); abort = 1'b0;     // back to IDLE
        trig = 1'b1;
        beat(32'hE0); beat(32'hE1);
        trig = 1'b0;
        chk("t5_trig_idle_busy", 64'(busy), 0);
        arm = 1'b1; trig = 1'b1;
        beat(32'hE2);
        arm = 1'b0; trig = 1'b0;
        chk("t5_arm_trig_same", 64'(busy), 1);
        beat(32'hE3); beat(32'hE4);
        chk("t5_still_armed_wc", 64'(wcount), 0);
        pulse_trig();
        push(13'h0000, 32'hB0); push(13'h0001, 32'hB1);
        beat(32'hB0); beat(32'hB1);
        chk("t5_cap1_bank", 64'(bank), 1);
        pulse_arm();
        pulse_trig();
        push(13'h1000, 32'hB2); push(13'h1001, 32'hB3);
        beat(32'hB2); beat(32'hB3);
        chk("t5_cap2_bank", 64'(bank), 0);
        chk("t5_cap2_done", 64'(done), 1);

        // ---------------- async reset mid-capture ----------------
        length = 4;
        pulse_arm();
        pulse_trig();
        push(13'h0000, 32'hC0);
        beat(32'hC0);
        s_tvalid = 1'b1; s_tdata = DW'(32'hC1);
        @(posedge clk);                 // write 2 becomes visible here
        #2 areset = 1'b1;
        #1;
        chk("t6_we",     64'(bram_we), 0);
        chk("t6_busy",   64'(busy), 0);
        chk("t6_bank",   64'(bank), 0);
        chk("t6_tready", 64'(s_tready), 0);
        chk("t6_wcount", 64'(wcount), 0);
        tick(); tick();
        areset = 1'b0;
        s_tvalid = 1'b0;
        tick();
        chk("t6_tready_rel", 64'(s_tready), 1);
        chk("t6_idle",       64'(busy), 0);
        pulse_trig();
        beat(32'hD0); beat(32'hD1);
        chk("t6_idle_after_trig", 64'(busy), 0);
        tick(); tick();

        chk("queue_empty", 64'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
